wb_tag_fill: RTL and testbench

Wishbone master engine that programs memory-tag granules over a contiguous region by issuing tag-write transactions (sel = 4'b0101) to the tagged RAM slave. It sits directly upstream of the tagged RAM on the bus, driven by a simple start/parameter interface from the CPU-side control logic. It can optionally read back each tag to verify it. It reports completion, progress and error status.

---
 rtl/wb_tag_fill.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_tag_fill.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tag_fill.sv
// Wishbone master that writes one tag per granule over a contiguous region,
// with optional read-back verification, abort handling and request timeout.
module wb_tag_fill #(
    parameter int WB_DATA_WIDTH      = 32,
    parameter int WB_ADDR_WIDTH      = 32,
    parameter int GRANULE_SIZE_BYTES = 16,
    parameter int GRANULE_TAG_WIDTH  = 4,
    parameter int COUNT_WIDTH        = 16,
    parameter int TIMEOUT_CYCLES     = 15
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [WB_ADDR_WIDTH-1:0]     base_addr_i,
    input  logic [COUNT_WIDTH-1:0]       count_i,
    input  logic [GRANULE_TAG_WIDTH-1:0] tag_i,
    input  logic                         verify_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [1:0]                   status_o,
    output logic [WB_ADDR_WIDTH-1:0]     err_addr_o,
    output logic [COUNT_WIDTH-1:0]       granules_done_o,
    output logic [WB_ADDR_WIDTH-1:0]     wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0]     wb_data_o,
    output logic [WB_DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic                         wb_we_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    input  logic                         wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]     wb_data_i
);

    localparam int SEL_W = WB_DATA_WIDTH / 8;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SEL_W-1:0]         SEL_TAG   = SEL_W'(4'b0101);
    localparam logic [WB_ADDR_WIDTH-1:0] GRAN_MASK = WB_ADDR_WIDTH'(GRANULE_SIZE_BYTES - 1);
    localparam logic [WB_ADDR_WIDTH-1:0] GRAN_STEP = WB_ADDR_WIDTH'(GRANULE_SIZE_BYTES);
    localparam logic [TMO_W-1:0]         TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]         TMO_ONE   = TMO_W'(1);
    localparam logic [COUNT_WIDTH-1:0]   CNT_ONE   = COUNT_WIDTH'(1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_ABORT    = 2'b11;

    typedef enum logic [2:0] {IDLE, WREQ, RREQ, GAP, DONE} state_t;

    state_t                       state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0]     cur_q, cur_d;
    logic [COUNT_WIDTH-1:0]       rem_q, rem_d;
    logic [COUNT_WIDTH-1:0]       gdone_q, gdone_d;
    logic [GRANULE_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                         vfy_q, vfy_d;
    logic                         rdp_q, rdp_d;
    logic                         abort_q, abort_d;
    logic                         err_q, err_d;
    logic [1:0]                   status_q, status_d;
    logic [WB_ADDR_WIDTH-1:0]     erra_q, erra_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;

    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [WB_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0]     data_q, data_d;
    logic [SEL_W-1:0]             sel_q, sel_d;
    logic                         we_q, we_d;
    logic                         cyc_q, cyc_d;
    logic                         req_d;

    // Only the tag field of the read data is meaningful.
    logic unused_rdata;
    assign unused_rdata = ^wb_data_i[WB_DATA_WIDTH-1:GRANULE_TAG_WIDTH];

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rem_d    = rem_q;
        gdone_d  = gdone_q;
        tag_d    = tag_q;
        vfy_d    = vfy_q;
        rdp_d    = rdp_q;
        abort_d  = abort_q;
        err_d    = err_q;
        status_d = status_q;
        erra_d   = erra_q;
        tmo_d    = '0;

        if (state_q == WREQ || state_q == RREQ || state_q == GAP) begin
            abort_d = abort_q | abort_i;
        end

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    status_d = ST_OK;
                    gdone_d  = '0;
                    erra_d   = '0;
                    err_d    = 1'b0;
                    rdp_d    = 1'b0;
                    if (count_i != '0) begin
                        cur_d   = base_addr_i & ~GRAN_MASK;
                        rem_d   = count_i;
                        tag_d   = tag_i;
                        vfy_d   = verify_i;
                        state_d = WREQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WREQ: begin
                if (wb_ack_i) begin
                    if (vfy_q) begin
                        rdp_d = 1'b1;
                    end else begin
                        gdone_d = gdone_q + CNT_ONE;
                        rem_d   = rem_q - CNT_ONE;
                        cur_d   = cur_q + GRAN_STEP;
                    end
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    erra_d   = cur_q;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            RREQ: begin
                if (wb_ack_i) begin
                    rdp_d = 1'b0;
                    if (wb_data_i[GRANULE_TAG_WIDTH-1:0] == tag_q) begin
                        gdone_d = gdone_q + CNT_ONE;
                        rem_d   = rem_q - CNT_ONE;
                        cur_d   = cur_q + GRAN_STEP;
                    end else begin
                        status_d = ST_MISMATCH;
                        erra_d   = cur_q;
                        err_d    = 1'b1;
                    end
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    erra_d   = cur_q;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            GAP: begin
                // An abort wins over a pending read-back of the granule just written.
                if (rdp_q && !abort_q) begin
                    state_d = RREQ;
                end else if (err_q || abort_q || rem_q == '0) begin
                    if (abort_q && !err_q) begin
                        status_d = ST_ABORT;
                    end
                    rdp_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = WREQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus and status outputs are registered from the next state.
        req_d  = (state_d == WREQ) || (state_d == RREQ);
        cyc_d  = req_d;
        we_d   = (state_d == WREQ);
        sel_d  = req_d ? SEL_TAG : '0;
        addr_d = req_d ? cur_d : '0;
        data_d = req_d ? WB_DATA_WIDTH'(tag_d) : '0;
        busy_d = req_d || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rem_q    <= '0;
            gdone_q  <= '0;
            tag_q    <= '0;
            vfy_q    <= 1'b0;
            rdp_q    <= 1'b0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            status_q <= '0;
            erra_q   <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
            gdone_q  <= gdone_d;
            tag_q    <= tag_d;
            vfy_q    <= vfy_d;
            rdp_q    <= rdp_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            status_q <= status_d;
            erra_q   <= erra_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign status_o        = status_q;
    assign err_addr_o      = erra_q;
    assign granules_done_o = gdone_q;
    assign wb_addr_o       = addr_q;
    assign wb_data_o       = data_q;
    assign wb_sel_o        = sel_q;
    assign wb_we_o         = we_q;
    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = cyc_q;

endmodule

// File: tb/tb_wb_tag_fill.sv
// Bench for wb_tag_fill: Wishbone slave model with one-cycle ack latency,
// bus-transaction and result scoreboards.
module tb_wb_tag_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] count_i = '0;
    logic [3:0]  tag_i = '0;
    logic        verify_i = 1'b0;
    logic        busy_o, done_o;
    logic [1:0]  status_o;
    logic [31:0] err_addr_o;
    logic [15:0] granules_done_o;
    logic [31:0] wb_addr_o, wb_data_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_data_i = '0;

    wb_tag_fill dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (rst_n),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .base_addr_i     (base_addr_i),
        .count_i         (count_i),
        .tag_i           (tag_i),
        .verify_i        (verify_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .status_o        (status_o),
        .err_addr_o      (err_addr_o),
        .granules_done_o (granules_done_o),
        .wb_addr_o       (wb_addr_o),
        .wb_data_o       (wb_data_o),
        .wb_sel_o        (wb_sel_o),
        .wb_we_o         (wb_we_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_ack_i        (wb_ack_i),
        .wb_data_i       (wb_data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] gd;
        logic [31:0] ea;
    } res_t;

    txn_t exp_q[$];
    res_t res_q[$];

    int errors = 0;
    int checks = 0;
    int cnt = 0;
    int cyc_hi = 0;
    int wr_idx = 0;
    int abort_k = 0;
    bit noack = 1'b0;
    bit seen = 1'b0;
    logic [31:0] bad_addr = 32'h1;
    logic [31:0] last_wdata = '0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave model: ack in the second cycle of every request, check it against the scoreboard.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            abort_i = 1'b0;
            if (wb_cyc_o) cyc_hi++;
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                seen = 1'b0;
                check("gap_after_ack", {63'd0, wb_cyc_o}, 64'd0);
            end else if (wb_cyc_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (wb_we_o) begin
                        wr_idx++;
                        if (wr_idx == abort_k) abort_i = 1'b1;
                    end
                end else if (!noack) begin
                    wb_ack_i = 1'b1;
                    wb_data_i = (wb_addr_o == bad_addr) ? 32'h5 : last_wdata;
                    if (wb_we_o) last_wdata = wb_data_o;
                    check("sel_stb", {59'd0, wb_sel_o, wb_stb_o}, {59'd0, 4'b0101, 1'b1});
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", {32'd0, wb_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        t = exp_q.pop_front();
                        check("txn_addr", {32'd0, wb_addr_o}, {32'd0, t.addr});
                        check("txn_we", {63'd0, wb_we_o}, {63'd0, t.we});
                        if (t.we) check("txn_data", {32'd0, wb_data_o}, {32'd0, t.data});
                    end
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Builds expected traffic and result from the operation parameters, then runs it.
    task automatic run(input logic [31:0] base, input logic [15:0] count, input logic [3:0] tag,
                       input bit vfy, input logic [31:0] bad, input bit na, input int abk,
                       input int exp_lat, input int exp_cyc_hi);
        logic [31:0] a;
        res_t r, got_r;
        bit got;
        int t0;
        r = '0;
        if (count != 0) begin
            if (na) begin
                r.st = 2'b10;
                r.ea = base & ~32'hF;
            end else begin
                for (int i = 0; i < int'(count); i++) begin
                    a = (base & ~32'hF) + 32'(16 * i);
                    exp_q.push_back({a, 1'b1, {28'd0, tag}});
                    if (abk != 0 && i + 1 == abk) begin
                        if (!vfy) r.gd++;
                        r.st = 2'b11;
                        break;
                    end
                    if (vfy) begin
                        exp_q.push_back({a, 1'b0, 32'd0});
                        if (a == bad) begin
                            r.st = 2'b01;
                            r.ea = a;
                            break;
                        end
                    end
                    r.gd++;
                end
            end
        end
        res_q.push_back(r);
        noack = na; abort_k = abk; bad_addr = bad; wr_idx = 0;
        @(negedge clk);
        cyc_hi = 0;
        base_addr_i = base; count_i = count; tag_i = tag; verify_i = vfy; start_i = 1'b1;
        @(posedge clk);
        #1;
        t0 = cnt;
        start_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_rise", {63'd0, busy_o}, {63'd0, count != 0});
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("done_seen", 64'd0, 64'd1);
        end else begin
            if (exp_lat >= 0) check("done_latency", 64'(cnt - t0), 64'(exp_lat));
            check("busy_at_done", {63'd0, busy_o}, 64'd0);
            got_r = res_q.pop_front();
            check("status", {62'd0, status_o}, {62'd0, got_r.st});
            check("granules_done", {48'd0, granules_done_o}, {48'd0, got_r.gd});
            check("err_addr", {32'd0, err_addr_o}, {32'd0, got_r.ea});
            check("txn_left", 64'(exp_q.size()), 64'd0);
            if (exp_cyc_hi >= 0) check("cyc_high_cycles", 64'(cyc_hi), 64'(exp_cyc_hi));
        end
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        check("done_one_cycle", {63'd0, done_o}, 64'd0);
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_cyc_stb_we", {61'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'd0);
        check("rst_sel", {60'd0, wb_sel_o}, 64'd0);
        check("rst_status", {62'd0, status_o}, 64'd0);
        check("rst_addr_data", {wb_addr_o, wb_data_o}, 64'd0);
        check("rst_gd_ea", {16'd0, granules_done_o, err_addr_o}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(32'h104, 16'd3, 4'hA, 1'b0, 32'h1, 1'b0, 0, 9, -1);
        run(32'h100, 16'd3, 4'hA, 1'b1, 32'h110, 1'b0, 0, -1, -1);
        run(32'h200, 16'd4, 4'h6, 1'b0, 32'h1, 1'b1, 0, 15, 15);
        run(32'h400, 16'd8, 4'h3, 1'b0, 32'h1, 1'b0, 3, 9, -1);
        run(32'h500, 16'd0, 4'h9, 1'b0, 32'h1, 1'b0, 0, 0, 0);
        run(32'hFFFF_FFF0, 16'd2, 4'hC, 1'b0, 32'h1, 1'b0, 0, 6, -1);
        run(32'h60C, 16'd2, 4'h7, 1'b1, 32'h1, 1'b0, 0, 12, -1);

        // Asynchronous reset during the read-back request.
        exp_q.push_back({32'h300, 1'b1, 32'h0000_000E});
        noack = 1'b0; abort_k = 0; bad_addr = 32'h1;
        @(negedge clk);
        base_addr_i = 32'h300; count_i = 16'd2; tag_i = 4'hE; verify_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (wb_cyc_o && !wb_we_o) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_rreq", {63'd0, hit}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cyc", {63'd0, wb_cyc_o}, 64'd0);
        check("arst_busy", {63'd0, busy_o}, 64'd0);
        check("arst_status_sel", {58'd0, status_o, wb_sel_o}, 64'd0);
        check("arst_txn_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("arst_no_done", {63'd0, done_o}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(32'h700, 16'd1, 4'h2, 1'b0, 32'h1, 1'b0, 0, 3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
